// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave byte engine.
package i2c_pkg;

   localparam int         I2C_BYTE_W  = 8;
   localparam logic [6:0] I2C_GC_ADDR = 7'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX,
      ST_RX_ACK,
      ST_TX,
      ST_TX_ACK,
      ST_WAIT_STOP
   } i2c_state_e;

endpackage

// File: rtl/i2c_shift8.sv
// 8-bit MSB-first shift register with parallel load, 3-bit bit counter and byte-complete flag.
module i2c_shift8
   import i2c_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_load,
   input  logic [I2C_BYTE_W-1:0] i_load_data,
   input  logic                  i_shift,
   input  logic                  i_sda,
   output logic [I2C_BYTE_W-1:0] o_data,
   output logic [2:0]            o_cnt,
   output logic                  o_byte_done
);

   logic [I2C_BYTE_W-1:0] r_data;
   logic [2:0]            r_cnt;
   logic                  r_done;

   // Clear only rewinds the counter; the data stays readable for the cycle that consumes it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_data <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (i_load) begin
         r_data <= i_load_data;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (i_shift) begin
         r_data <= {r_data[I2C_BYTE_W-2:0], i_sda};
         r_cnt  <= r_cnt + 3'd1;
         r_done <= (r_cnt == 3'd7);
      end
   end

   assign o_data      = r_data;
   assign o_cnt       = r_cnt;
   assign o_byte_done = r_done;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave byte engine: address match, ACK/NACK generation and rx/tx byte handshakes.
module i2c_slave_byte_engine
   import i2c_pkg::*;
#(
   parameter int         NUM_ADDR = 2,
   parameter bit         GC_EN    = 1'b1,
   parameter logic [7:0] TX_IDLE  = 8'hFF
)(
   input  logic                  i_pclk,
   input  logic                  i_presetn,
   input  logic                  i_scl_rise,
   input  logic                  i_scl_fall,
   input  logic                  i_start_det,
   input  logic                  i_stop_det,
   input  logic                  i_sda_in,
   input  logic [7*NUM_ADDR-1:0] i_slave_addr,
   input  logic [NUM_ADDR-1:0]   i_addr_en,
   input  logic [7:0]            i_tx_data,
   input  logic                  i_tx_valid,
   input  logic                  i_rx_ready,
   output logic [7:0]            o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_tx_req,
   output logic                  o_sda_low,
   output logic [1:0]            o_addr_idx,
   output logic                  o_rw,
   output logic                  o_busy,
   output logic                  o_rx_overrun,
   output logic                  o_tx_underrun
);

   i2c_state_e r_state;
   logic [7:0] r_rx_data;
   logic       r_rx_valid, r_tx_req, r_sda_low, r_rw, r_mack;
   logic       r_rx_overrun, r_tx_underrun;
   logic [1:0] r_addr_idx;

   logic [7:0] w_sh, w_tx_byte;
   logic [2:0] w_cnt;
   logic       w_byte_done, w_rise, w_fall, w_no_evt;
   logic       w_clr, w_load, w_shift;
   logic       w_match;
   logic [1:0] w_match_idx;

   // A simultaneous rise and fall is a protocol error and is handled as a fall only.
   assign w_rise    = i_scl_rise & ~i_scl_fall;
   assign w_fall    = i_scl_fall;
   assign w_no_evt  = ~i_start_det & ~i_stop_det;
   assign w_tx_byte = i_tx_valid ? i_tx_data : TX_IDLE;

   assign w_clr   = i_start_det
                  | (w_no_evt & w_fall & (((r_state == ST_ADDR) | (r_state == ST_RX)) & w_byte_done))
                  | (w_no_evt & w_fall & (r_state == ST_TX) & (w_cnt == 3'd7));
   assign w_load  = w_no_evt & w_fall & (((r_state == ST_ADDR_ACK) & r_rw)
                                       | ((r_state == ST_TX_ACK) & ~r_mack));
   assign w_shift = w_no_evt & ((w_rise & ((r_state == ST_ADDR) | (r_state == ST_RX)))
                              | (w_fall & (r_state == ST_TX) & (w_cnt != 3'd7)));

   i2c_shift8 u_shift (
      .i_clk       (i_pclk),
      .i_rst_n     (i_presetn),
      .i_clr       (w_clr),
      .i_load      (w_load),
      .i_load_data (w_tx_byte),
      .i_shift     (w_shift),
      .i_sda       (i_sda_in),
      .o_data      (w_sh),
      .o_cnt       (w_cnt),
      .o_byte_done (w_byte_done)
   );

   // Descending scan so the lowest enabled matching entry wins.
   always_comb begin
      w_match     = 1'b0;
      w_match_idx = '0;
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
         if (i_addr_en[i] && (i_slave_addr[7*i +: 7] == w_sh[7:1])) begin
            w_match     = 1'b1;
            w_match_idx = 2'(i);
         end
      end
      if (!w_match && GC_EN && (w_sh[7:1] == I2C_GC_ADDR) && !w_sh[0]) begin
         w_match     = 1'b1;
         w_match_idx = 2'(NUM_ADDR);
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         r_state       <= ST_IDLE;
         r_sda_low     <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_tx_req      <= 1'b0;
         r_addr_idx    <= '0;
         r_rw          <= 1'b0;
         r_mack        <= 1'b1;
         r_rx_overrun  <= 1'b0;
         r_tx_underrun <= 1'b0;
      end else begin
         r_tx_req      <= 1'b0;
         r_rx_overrun  <= 1'b0;
         r_tx_underrun <= 1'b0;
         if (r_rx_valid && i_rx_ready)
            r_rx_valid <= 1'b0;
         if (i_start_det) begin
            r_state   <= ST_ADDR;
            r_sda_low <= 1'b0;
         end else if (i_stop_det) begin
            r_state   <= ST_IDLE;
            r_sda_low <= 1'b0;
         end else begin
            case (r_state)
               ST_ADDR: if (w_fall && w_byte_done) begin
                  if (w_match) begin
                     r_state    <= ST_ADDR_ACK;
                     r_sda_low  <= 1'b1;
                     r_addr_idx <= w_match_idx;
                     r_rw       <= w_sh[0];
                     r_tx_req   <= w_sh[0];
                  end else begin
                     r_state <= ST_WAIT_STOP;
                  end
               end
               ST_ADDR_ACK: if (w_fall) begin
                  if (r_rw) begin
                     r_state       <= ST_TX;
                     r_sda_low     <= ~w_tx_byte[7];
                     r_tx_underrun <= ~i_tx_valid;
                  end else begin
                     r_state   <= ST_RX;
                     r_sda_low <= 1'b0;
                  end
               end
               // A byte is only accepted if the previous one is gone or leaves this very cycle.
               ST_RX: if (w_fall && w_byte_done) begin
                  r_state <= ST_RX_ACK;
                  if (!r_rx_valid || i_rx_ready) begin
                     r_rx_data  <= w_sh;
                     r_rx_valid <= 1'b1;
                     r_sda_low  <= 1'b1;
                  end else begin
                     r_sda_low    <= 1'b0;
                     r_rx_overrun <= 1'b1;
                  end
               end
               ST_RX_ACK: if (w_fall) begin
                  r_state   <= ST_RX;
                  r_sda_low <= 1'b0;
               end
               ST_TX: if (w_fall) begin
                  if (w_cnt == 3'd7) begin
                     r_state   <= ST_TX_ACK;
                     r_sda_low <= 1'b0;
                     r_mack    <= 1'b1;
                  end else begin
                     r_sda_low <= ~w_sh[6];
                  end
               end
               ST_TX_ACK: begin
                  if (w_fall) begin
                     if (!r_mack) begin
                        r_state       <= ST_TX;
                        r_sda_low     <= ~w_tx_byte[7];
                        r_tx_req      <= 1'b1;
                        r_tx_underrun <= ~i_tx_valid;
                     end else begin
                        r_state <= ST_WAIT_STOP;
                     end
                  end else if (w_rise) begin
                     r_mack <= i_sda_in;
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign o_rx_data     = r_rx_data;
   assign o_rx_valid    = r_rx_valid;
   assign o_tx_req      = r_tx_req;
   assign o_sda_low     = r_sda_low;
   assign o_addr_idx    = r_addr_idx;
   assign o_rw          = r_rw;
   assign o_busy        = (r_state != ST_IDLE) && (r_state != ST_WAIT_STOP);
   assign o_rx_overrun  = r_rx_overrun;
   assign o_tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Directed bench for i2c_slave_byte_engine: a strobe-level I2C master drives a wired-AND SDA bus.
module tb_i2c_slave_byte_engine;

   logic        r_pclk = 1'b0, r_presetn = 1'b0;
   logic        r_scl_rise = 1'b0, r_scl_fall = 1'b0, r_start = 1'b0, r_stop = 1'b0;
   logic        r_msda = 1'b1;
   logic [13:0] r_slave_addr = {7'h51, 7'h3A};
   logic [1:0]  r_addr_en = 2'b11;
   logic [7:0]  r_tx_data = 8'h00;
   logic        r_tx_valid = 1'b0, r_rx_ready = 1'b1;

   logic [7:0]  w_rx_data;
   logic [1:0]  w_addr_idx;
   logic        w_rx_valid, w_tx_req, w_sda_low, w_rw, w_busy, w_rx_overrun, w_tx_underrun;
   logic        w_sda;

   int checks = 0, errors = 0;
   int n_tx_req = 0, n_ovr = 0, n_unr = 0;

   assign w_sda = r_msda & ~w_sda_low;

   i2c_slave_byte_engine #(.NUM_ADDR(2), .GC_EN(1'b1), .TX_IDLE(8'hFF)) dut (
      .i_pclk        (r_pclk),
      .i_presetn     (r_presetn),
      .i_scl_rise    (r_scl_rise),
      .i_scl_fall    (r_scl_fall),
      .i_start_det   (r_start),
      .i_stop_det    (r_stop),
      .i_sda_in      (w_sda),
      .i_slave_addr  (r_slave_addr),
      .i_addr_en     (r_addr_en),
      .i_tx_data     (r_tx_data),
      .i_tx_valid    (r_tx_valid),
      .i_rx_ready    (r_rx_ready),
      .o_rx_data     (w_rx_data),
      .o_rx_valid    (w_rx_valid),
      .o_tx_req      (w_tx_req),
      .o_sda_low     (w_sda_low),
      .o_addr_idx    (w_addr_idx),
      .o_rw          (w_rw),
      .o_busy        (w_busy),
      .o_rx_overrun  (w_rx_overrun),
      .o_tx_underrun (w_tx_underrun)
   );

   always #5 r_pclk = ~r_pclk;

   // Pulse counters sample mid-cycle, clear of both clock edges.
   always @(posedge r_pclk) begin
      #3;
      if (w_tx_req === 1'b1)      n_tx_req++;
      if (w_rx_overrun === 1'b1)  n_ovr++;
      if (w_tx_underrun === 1'b1) n_unr++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic pulse_rise();
      @(negedge r_pclk) r_scl_rise = 1'b1;
      @(negedge r_pclk) r_scl_rise = 1'b0;
   endtask

   task automatic pulse_fall();
      @(negedge r_pclk) r_scl_fall = 1'b1;
      @(negedge r_pclk) r_scl_fall = 1'b0;
   endtask

   task automatic i2c_start();
      @(negedge r_pclk) begin r_msda = 1'b1; r_start = 1'b1; end
      @(negedge r_pclk) r_start = 1'b0;
      pulse_fall();
   endtask

   task automatic i2c_stop();
      @(negedge r_pclk) r_stop = 1'b1;
      @(negedge r_pclk) begin r_stop = 1'b0; r_msda = 1'b1; end
   endtask

   task automatic send_bit(input logic b);
      @(negedge r_pclk) r_msda = b;
      pulse_rise();
      pulse_fall();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic ack_slot(output logic acked);
      @(negedge r_pclk) r_msda = 1'b1;
      pulse_rise();
      acked = ~w_sda;
      pulse_fall();
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] data);
      for (int i = 7; i >= 0; i--) begin
         pulse_rise();
         data[i] = w_sda;
         pulse_fall();
      end
      @(negedge r_pclk) r_msda = ~mack;
      pulse_rise();
      pulse_fall();
      @(negedge r_pclk) r_msda = 1'b1;
   endtask

   task automatic test_reset();
      r_presetn = 1'b0;
      repeat (3) @(negedge r_pclk);
      checks++;
      if ({w_rx_data, w_rx_valid, w_tx_req, w_addr_idx, w_rw, w_rx_overrun, w_tx_underrun} !== 15'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got rx_data=%h rx_valid=%b tx_req=%b idx=%0d rw=%b ovr=%b unr=%b, expected all 0",
                  w_rx_data, w_rx_valid, w_tx_req, w_addr_idx, w_rw, w_rx_overrun, w_tx_underrun);
      end
      checks++;
      if (w_sda_low !== 1'b0 || w_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_sda_busy: sda_low=%b busy=%b, expected 0 0", w_sda_low, w_busy);
      end
      @(negedge r_pclk) r_presetn = 1'b1;
      @(negedge r_pclk);
   endtask

   task automatic test_write();
      logic a;
      r_rx_ready = 1'b1;
      i2c_start();
      checks++;
      if (w_busy !== 1'b1) begin errors++; $display("[TB] FAIL write_busy_after_start: busy=%b expected 1", w_busy); end
      send_byte(8'h74);
      checks++;
      if (w_sda_low !== 1'b1 || w_addr_idx !== 2'd0 || w_rw !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_addr_ack: sda_low=%b idx=%0d rw=%b, expected 1 0 0", w_sda_low, w_addr_idx, w_rw);
      end
      ack_slot(a);
      checks++;
      if (a !== 1'b1 || w_sda_low !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_ack_release: acked=%b sda_low=%b, expected 1 0", a, w_sda_low);
      end
      send_byte(8'hA5);
      checks++;
      if (w_sda_low !== 1'b1 || w_rx_valid !== 1'b1 || w_rx_data !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL write_data: sda_low=%b rx_valid=%b rx_data=%h, expected 1 1 a5", w_sda_low, w_rx_valid, w_rx_data);
      end
      @(negedge r_pclk);
      checks++;
      if (w_rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL write_rx_valid_one_cycle: rx_valid=%b expected 0", w_rx_valid); end
      ack_slot(a);
      i2c_stop();
      checks++;
      if (w_busy !== 1'b0 || w_sda_low !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_stop_idle: busy=%b sda_low=%b, expected 0 0", w_busy, w_sda_low);
      end
   endtask

   task automatic test_multi_addr();
      logic a;
      i2c_start();
      send_byte(8'hA2);
      checks++;
      if (w_sda_low !== 1'b1 || w_addr_idx !== 2'd1) begin
         errors++;
         $display("[TB] FAIL multi_addr1_ack: sda_low=%b idx=%0d, expected 1 1", w_sda_low, w_addr_idx);
      end
      ack_slot(a);
      i2c_stop();
      r_addr_en = 2'b01;
      i2c_start();
      send_byte(8'hA2);
      checks++;
      if (w_sda_low !== 1'b0 || w_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL multi_addr1_disabled: sda_low=%b busy=%b, expected 0 0", w_sda_low, w_busy);
      end
      ack_slot(a);
      send_byte(8'h00);
      checks++;
      if (a !== 1'b0 || w_sda_low !== 1'b0) begin
         errors++;
         $display("[TB] FAIL multi_wait_stop: acked=%b sda_low=%b, expected 0 0", a, w_sda_low);
      end
      i2c_stop();
      r_addr_en = 2'b11;
   endtask

   task automatic test_general_call();
      logic a;
      i2c_start();
      send_byte(8'h00);
      checks++;
      if (w_sda_low !== 1'b1 || w_addr_idx !== 2'd2 || w_rw !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gc_ack: sda_low=%b idx=%0d rw=%b, expected 1 2 0", w_sda_low, w_addr_idx, w_rw);
      end
      ack_slot(a);
      i2c_stop();
      i2c_start();
      send_byte(8'h01);
      checks++;
      if (w_sda_low !== 1'b0 || w_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gc_read_nack: sda_low=%b busy=%b, expected 0 0", w_sda_low, w_busy);
      end
      i2c_stop();
   endtask

   task automatic test_read();
      logic a;
      logic [7:0] d;
      int base_req, base_unr;
      base_req   = n_tx_req;
      base_unr   = n_unr;
      r_tx_data  = 8'h3C;
      r_tx_valid = 1'b1;
      i2c_start();
      send_byte(8'h75);
      checks++;
      if (w_sda_low !== 1'b1 || w_rw !== 1'b1 || n_tx_req !== base_req + 1) begin
         errors++;
         $display("[TB] FAIL read_addr: sda_low=%b rw=%b tx_req=%0d, expected 1 1 %0d", w_sda_low, w_rw, n_tx_req, base_req + 1);
      end
      ack_slot(a);
      r_tx_data = 8'hC3;
      read_byte(1'b1, d);
      checks++;
      if (d !== 8'h3C) begin errors++; $display("[TB] FAIL read_byte0: got %h expected 3c", d); end
      checks++;
      if (n_tx_req !== base_req + 2) begin
         errors++;
         $display("[TB] FAIL read_tx_req_count: got %0d expected %0d", n_tx_req, base_req + 2);
      end
      read_byte(1'b0, d);
      checks++;
      if (d !== 8'hC3) begin errors++; $display("[TB] FAIL read_byte1: got %h expected c3", d); end
      checks++;
      if (w_busy !== 1'b0 || n_unr !== base_unr || n_tx_req !== base_req + 2) begin
         errors++;
         $display("[TB] FAIL read_nack_wait_stop: busy=%b underruns=%0d tx_req=%0d, expected 0 %0d %0d",
                  w_busy, n_unr - base_unr, n_tx_req, 0, base_req + 2);
      end
      i2c_stop();
   endtask

   task automatic test_overrun_underrun();
      logic a;
      logic [7:0] d;
      int base_ovr, base_unr;
      base_ovr   = n_ovr;
      base_unr   = n_unr;
      r_rx_ready = 1'b0;
      i2c_start();
      send_byte(8'h74);
      ack_slot(a);
      send_byte(8'h11);
      checks++;
      if (w_sda_low !== 1'b1 || w_rx_valid !== 1'b1 || w_rx_data !== 8'h11) begin
         errors++;
         $display("[TB] FAIL ovr_first_byte: sda_low=%b rx_valid=%b rx_data=%h, expected 1 1 11", w_sda_low, w_rx_valid, w_rx_data);
      end
      ack_slot(a);
      send_byte(8'h22);
      checks++;
      if (w_sda_low !== 1'b0 || n_ovr !== base_ovr + 1) begin
         errors++;
         $display("[TB] FAIL ovr_nack: sda_low=%b overruns=%0d, expected 0 1", w_sda_low, n_ovr - base_ovr);
      end
      checks++;
      if (w_rx_valid !== 1'b1 || w_rx_data !== 8'h11) begin
         errors++;
         $display("[TB] FAIL ovr_data_kept: rx_valid=%b rx_data=%h, expected 1 11", w_rx_valid, w_rx_data);
      end
      ack_slot(a);
      i2c_stop();
      @(negedge r_pclk) r_rx_ready = 1'b1;
      @(negedge r_pclk);
      checks++;
      if (w_rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_drain: rx_valid=%b expected 0", w_rx_valid); end
      r_tx_valid = 1'b0;
      i2c_start();
      send_byte(8'h75);
      ack_slot(a);
      checks++;
      if (n_unr !== base_unr + 1) begin
         errors++;
         $display("[TB] FAIL unr_pulse: underruns=%0d expected 1", n_unr - base_unr);
      end
      read_byte(1'b0, d);
      checks++;
      if (d !== 8'hFF) begin errors++; $display("[TB] FAIL unr_idle_byte: got %h expected ff", d); end
      i2c_stop();
   endtask

   task automatic test_rise_fall_collision();
      logic a;
      i2c_start();
      @(negedge r_pclk) begin r_msda = 1'b1; r_scl_rise = 1'b1; r_scl_fall = 1'b1; end
      @(negedge r_pclk) begin r_scl_rise = 1'b0; r_scl_fall = 1'b0; end
      send_byte(8'h74);
      checks++;
      if (w_sda_low !== 1'b1 || w_addr_idx !== 2'd0) begin
         errors++;
         $display("[TB] FAIL collision_as_fall: sda_low=%b idx=%0d, expected 1 0", w_sda_low, w_addr_idx);
      end
      ack_slot(a);
      i2c_stop();
   endtask

   task automatic test_repeated_start();
      logic a;
      r_rx_ready = 1'b1;
      i2c_start();
      send_byte(8'h74);
      ack_slot(a);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      i2c_start();
      checks++;
      if (w_busy !== 1'b1 || w_sda_low !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstart_state: busy=%b sda_low=%b, expected 1 0", w_busy, w_sda_low);
      end
      send_byte(8'hA2);
      checks++;
      if (w_sda_low !== 1'b1 || w_addr_idx !== 2'd1 || w_rw !== 1'b0 || w_rx_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstart_new_addr: sda_low=%b idx=%0d rw=%b rx_valid=%b, expected 1 1 0 0",
                  w_sda_low, w_addr_idx, w_rw, w_rx_valid);
      end
      ack_slot(a);
      i2c_stop();
   endtask

   task automatic test_reset_mid_ack();
      i2c_start();
      send_byte(8'h74);
      checks++;
      if (w_sda_low !== 1'b1) begin errors++; $display("[TB] FAIL rst_ack_driven: sda_low=%b expected 1", w_sda_low); end
      @(negedge r_pclk) r_presetn = 1'b0;
      @(negedge r_pclk);
      checks++;
      if (w_sda_low !== 1'b0 || w_busy !== 1'b0 || w_addr_idx !== 2'd0) begin
         errors++;
         $display("[TB] FAIL rst_mid_ack: sda_low=%b busy=%b idx=%0d, expected 0 0 0", w_sda_low, w_busy, w_addr_idx);
      end
      @(negedge r_pclk) r_presetn = 1'b1;
      @(negedge r_pclk);
   endtask

   initial begin
      $display("[TB] starting i2c_slave_byte_engine bench");
      test_reset();
      test_write();
      test_multi_addr();
      test_general_call();
      test_read();
      test_overrun_underrun();
      test_rise_fall_collision();
      test_repeated_start();
      test_reset_mid_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
